// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: shared cbus request/response types used by the fetch and data ports
package cbus_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] addr;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: two-port (fetch/data) arbiter onto one cbus with drain-before-regrant
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;
    typedef enum logic {GID_I, GID_D} gid_t;

    state_t state;
    gid_t   last_grant;
    logic   prev_ready;
    logic   done;
    logic   pick_d;

    // a downstream that holds ready high for several cycles completes only once
    assign done   = oresp.ready && oresp.last && !prev_ready;
    assign pick_d = dreq.valid && (!ireq.valid || ROUND_ROBIN == 0 || last_grant == GID_I);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GID_D;
            prev_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            prev_ready <= oresp.ready;
            case (state)
                IDLE: if (ireq.valid || dreq.valid) begin
                    state      <= pick_d ? GRANT_D : GRANT_I;
                    last_grant <= pick_d ? GID_D : GID_I;
                    busy       <= 1'b1;
                end
                GRANT_I: if (done || !ireq.valid) state <= DRAIN;
                GRANT_D: if (done || !dreq.valid) state <= DRAIN;
                DRAIN: if (!oresp.ready) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        oreq  = state == GRANT_I ? ireq : state == GRANT_D ? dreq : '0;
        iresp = state == GRANT_I ? oresp : '0;
        dresp = state == GRANT_D ? oresp : '0;
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: scoreboard bench for a round-robin (inst 0) and fixed-priority (inst 1) arbiter
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    typedef struct {
        int          k;
        bit          d;
        logic [31:0] a;
    } exp_t;

    localparam logic [31:0] KEY = 32'h5a5a_a5a5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    cbus_req_t  ireq[2], dreq[2], oreq[2];
    cbus_resp_t iresp[2], dresp[2], oresp[2], ot[2];
    logic       busy[2];
    logic       mem_en[2];
    int         mem_hold[2];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       gq[$];
    exp_t       rq[$];

    always #5 clk = ~clk;

    function automatic cbus_req_t mk(input logic [31:0] a, input bit d);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = d;
        r.size     = 2'd2;
        r.strobe   = d ? 4'hf : 4'h0;
        r.addr     = a;
        r.data     = d ? ~a : '0;
        return r;
    endfunction

    // memory model: ready+last with data = addr^KEY three cycles after a grant, held mem_hold cycles
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cbus_resp_t  m;
        int          cnt;
        int          hold;
        logic [31:0] a;

        cbus_arbiter #(.ROUND_ROBIN(g == 0 ? 1 : 0)) dut (
            .clk(clk), .rst(rst),
            .ireq(ireq[g]), .iresp(iresp[g]),
            .dreq(dreq[g]), .dresp(dresp[g]),
            .oreq(oreq[g]), .oresp(oresp[g]),
            .busy(busy[g])
        );

        assign oresp[g] = mem_en[g] ? m : ot[g];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m <= '0; cnt <= 0; hold <= 0; a <= '0;
            end else if (hold > 0) begin
                hold <= hold - 1;
                if (hold == 1) m <= '0;
            end else if (cnt > 0) begin
                if (cnt == 2) begin
                    m    <= '{ready: 1'b1, last: 1'b1, data: a ^ KEY};
                    hold <= mem_hold[g];
                    cnt  <= 0;
                end else cnt <= cnt + 1;
            end else if (oreq[g].valid) begin
                cnt <= 1;
                a   <= oreq[g].addr;
            end
        end
    end

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, want);
        end
    endtask

    task automatic expect_txn(input int k, input bit d, input logic [31:0] a, input bit resp);
        gq.push_back('{k: k, d: d, a: a});
        if (resp) rq.push_back('{k: k, d: d, a: a});
    endtask

    task automatic req(input int k, input bit d, input logic [31:0] a);
        if (d) dreq[k] = mk(a, 1'b1); else ireq[k] = mk(a, 1'b0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (d ? dresp[k].ready : iresp[k].ready) begin
                @(posedge clk); #1;
                if (d) dreq[k] = '0; else ireq[k] = '0;
                return;
            end
        end
        chk($sformatf("req_timeout inst%0d port%0d", k, d), 128'(1), 128'(0));
        if (d) dreq[k] = '0; else ireq[k] = '0;
    endtask

    task automatic monitor();
        logic pv[2];
        int   lr[2];
        exp_t e;
        pv = '{1'b0, 1'b0};
        lr = '{-100, -100};
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (oresp[k].ready) lr[k] = cyc;
                if (oreq[k].valid && !pv[k]) begin
                    chk("grant_after_drain", 128'(cyc - lr[k] >= 3), 128'(1));
                    if (gq.size() == 0) chk("grant_unexpected", 128'(oreq[k]), 128'(0));
                    else begin
                        e = gq.pop_front();
                        chk("grant_inst", 128'(k), 128'(e.k));
                        chk("grant_req", 128'(oreq[k]), 128'(mk(e.a, e.d)));
                    end
                end
                pv[k] = oreq[k].valid;
                if (iresp[k].ready || dresp[k].ready) begin
                    if (rq.size() == 0) chk("resp_unexpected", 128'({iresp[k], dresp[k]}), 128'(0));
                    else begin
                        e = rq.pop_front();
                        chk("resp_inst", 128'(k), 128'(e.k));
                        chk("resp_port", 128'(dresp[k].ready), 128'(e.d));
                        chk("resp_data", 128'(e.d ? dresp[k].data : iresp[k].data), 128'(e.a ^ KEY));
                        chk("resp_other_zero", 128'(e.d ? iresp[k] : dresp[k]), 128'(0));
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic zero_outputs(input string n, input int k);
        chk({n, "_oreq"}, 128'(oreq[k]), 128'(0));
        chk({n, "_iresp"}, 128'(iresp[k]), 128'(0));
        chk({n, "_dresp"}, 128'(dresp[k]), 128'(0));
        chk({n, "_busy"}, 128'(busy[k]), 128'(0));
    endtask

    task automatic contend(input int k, input logic [31:0] ai, input logic [31:0] ad, input bit d_first);
        if (d_first) begin
            expect_txn(k, 1'b1, ad, 1'b1);
            expect_txn(k, 1'b0, ai, 1'b1);
        end else begin
            expect_txn(k, 1'b0, ai, 1'b1);
            expect_txn(k, 1'b1, ad, 1'b1);
        end
        fork
            req(k, 1'b0, ai);
            req(k, 1'b1, ad);
        join
        idle(3);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_en[k] = 1'b1; mem_hold[k] = 1; ot[k] = '0; ireq[k] = '0; dreq[k] = '0;
        end
        fork monitor(); join_none
        idle(3);
        for (int k = 0; k < 2; k++) zero_outputs("in_reset", k);
        rst = 1'b0;
        idle(1);
        for (int k = 0; k < 2; k++) zero_outputs("after_reset", k);

        // round robin: first contention after reset goes to I, then alternates
        contend(0, 32'h0000_0100, 32'h1000_0200, 1'b0);
        contend(0, 32'h0000_0104, 32'h1000_0204, 1'b0);

        // single fetch: one-cycle arbitration latency
        expect_txn(0, 1'b0, 32'h8000_0000, 1'b1);
        fork
            req(0, 1'b0, 32'h8000_0000);
            begin
                @(negedge clk);
                chk("lat_idle_valid", 128'(oreq[0].valid), 128'(0));
                @(negedge clk);
                chk("lat_grant_valid", 128'(oreq[0].valid), 128'(1));
                chk("lat_grant_addr", 128'(oreq[0].addr), 128'(32'h8000_0000));
            end
        join
        idle(3);

        // registered-response downstream: ready+last held two cycles, fetch arrives while busy
        mem_hold[0] = 2;
        expect_txn(0, 1'b1, 32'h2000_0010, 1'b1);
        expect_txn(0, 1'b0, 32'h0000_0300, 1'b1);
        fork
            req(0, 1'b1, 32'h2000_0010);
            begin
                idle(2);
                chk("pending_busy", 128'(busy[0]), 128'(1));
                req(0, 1'b0, 32'h0000_0300);
            end
        join
        mem_hold[0] = 1;
        idle(3);

        // abort: data port drops valid after one granted cycle, stale ready arrives in DRAIN
        expect_txn(0, 1'b1, 32'h3000_0040, 1'b0);
        mem_en[0] = 1'b0;
        dreq[0] = mk(32'h3000_0040, 1'b1);
        idle(1);
        @(negedge clk);
        chk("abort_granted", 128'(oreq[0].valid), 128'(1));
        @(posedge clk); #1;
        dreq[0] = '0;
        #1;
        chk("abort_oreq_valid", 128'(oreq[0].valid), 128'(0));
        chk("abort_busy", 128'(busy[0]), 128'(1));
        @(posedge clk); #1;
        ot[0] = '{ready: 1'b1, last: 1'b1, data: 32'hdead_beef};
        #1;
        chk("abort_dresp", 128'(dresp[0]), 128'(0));
        chk("abort_iresp", 128'(iresp[0]), 128'(0));
        idle(1);
        chk("drain_hold_busy", 128'(busy[0]), 128'(1));
        @(posedge clk); #1;
        ot[0] = '0;
        chk("drain_exit_busy", 128'(busy[0]), 128'(1));
        idle(1);
        chk("drain_idle_busy", 128'(busy[0]), 128'(0));
        mem_en[0] = 1'b1;
        idle(2);

        // asynchronous reset in the middle of a fetch grant
        expect_txn(0, 1'b0, 32'h0000_1000, 1'b0);
        ireq[0] = mk(32'h0000_1000, 1'b0);
        idle(1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        zero_outputs("mid_reset", 0);
        ireq[0] = '0;
        idle(1);
        rst = 1'b0;
        idle(2);
        contend(0, 32'h0000_0500, 32'h1000_0600, 1'b0);

        // fixed priority: data wins every contention, fetch served when data idle
        contend(1, 32'h0000_0700, 32'h1000_0800, 1'b1);
        contend(1, 32'h0000_0704, 32'h1000_0804, 1'b1);
        expect_txn(1, 1'b0, 32'h0000_0900, 1'b1);
        req(1, 1'b0, 32'h0000_0900);
        idle(4);

        chk("grant_queue_empty", 128'(gq.size()), 128'(0));
        chk("resp_queue_empty", 128'(rq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate grant on contention, 0 = fixed data-port priority.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ireq  input  cbus_req_t  instruction-fetch request.
REQ-005 SHALL have port iresp  output  cbus_resp_t  instruction-fetch response.
REQ-006 SHALL have port dreq  input  cbus_req_t  data-memory request.
REQ-007 SHALL have port dresp  output  cbus_resp_t  data-memory response.
REQ-008 SHALL have port oreq  output  cbus_req_t  shared request toward address translation/memory.
REQ-009 SHALL have port oresp  input  cbus_resp_t  shared response.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, GRANT_I, GRANT_D, DRAIN.
REQ-012 IDLE: ireq.valid only -> GRANT_I; dreq.valid only -> GRANT_D; neither -> stay IDLE.
REQ-013 IDLE, both valid, ROUND_ROBIN=0 -> GRANT_D.
REQ-014 IDLE, both valid, ROUND_ROBIN=1 -> grant the port not recorded in last_grant register; last_grant updates on every grant.
REQ-015 Arbitration latency SHALL be exactly one cycle: oreq carries the winner's request in the cycle after IDLE samples valid.
REQ-016 In GRANT_x, oreq SHALL be a combinational copy of the granted port's request, all fields; in IDLE and DRAIN oreq SHALL be all-zero.
REQ-017 In GRANT_x, oresp SHALL be forwarded combinationally to the granted port's response; the other response output and both outputs in IDLE/DRAIN SHALL be all-zero.
REQ-018 Completion: in GRANT_x, oresp.ready && oresp.last in a cycle where previous-cycle oresp.ready was 0 (rising edge) -> DRAIN.
REQ-019 Abort: in GRANT_x, granted port's valid low before completion -> DRAIN; oreq.valid SHALL be 0 from that same cycle (combinational copy).
REQ-020 DRAIN: stay while oresp.ready==1; leave to IDLE on first cycle with oresp.ready==0, so a stale downstream response is never routed to a new owner.
REQ-021 The grant SHALL never change in GRANT_x, regardless of the other port's valid.
REQ-022 A request arriving while busy SHALL be held by its requester and served no earlier than the cycle after DRAIN exits.
REQ-023 ireq.valid and dreq.valid both high and completion in the same cycle -> DRAIN first; re-arbitration happens only in IDLE.
REQ-024 No request content SHALL be stored; a requester changing fields mid-grant is a protocol violation, not checked.

Reset
REQ-025 On rst: state=IDLE, last_grant=D (so first contended grant under ROUND_ROBIN=1 goes to I), prev-ready register=0.
REQ-026 During and immediately after reset: oreq, iresp, dresp all-zero, busy=0.
REQ-027 rst asserted mid-transaction SHALL abandon the grant with no completion pulse to either port.

Structure
REQ-028 cbus_req_t, cbus_resp_t SHALL come from the common package; the state enum and grant-id type SHALL be local to the module.
REQ-029 The rising-edge detect on oresp.ready SHALL be one small register plus gate inside the module; no sub-module.

Verification
REQ-030 ireq only, addr 0x8000_0000, memory model ready+last 3 cycles later -> oreq.addr 0x8000_0000 one cycle after valid; iresp.ready pulse with data; dresp stays 0.
REQ-031 Both valid same cycle after reset, ROUND_ROBIN=1 -> I granted first, then D; second contention -> I (alternation).
REQ-032 Same stimulus, ROUND_ROBIN=0 -> D granted on every contention; I served only when D idle.
REQ-033 D granted, dreq.valid dropped after 1 cycle while memory model holds ready for 2 more cycles -> oreq.valid 0 same cycle; DRAIN held until ready low; no dresp/iresp pulse.
REQ-034 Downstream holds ready+last high 2 cycles (registered-response model) -> exactly one completion; pending ireq granted only after ready returns low.
REQ-035 rst pulse while GRANT_I -> all outputs zero the same cycle, state IDLE; next request granted normally.
